// File: rtl/regfile_write_scheduler.sv
// ---------------------------------------------------------------------------
// regfile_write_scheduler
//
// Purpose:
//   Shares the single register-file write port between two writeback
//   requesters (A = ALU result, B = memory load). It also contains a
//   sequenced clear engine that zeroes registers 0..NUM_REGS-1, one per cycle.
//   The write-port outputs are registered on posedge clock_in, so the register
//   file's negedge write samples stable values.
//
// Parameters:
//   NUM_REGS  registers walked by the clear engine (addresses 0..NUM_REGS-1)
//   AW        register address width
//   DW        write data width
//
// Ports:
//   clock_in     in   system clock, posedge
//   rst          in   asynchronous reset, active-high
//   req_a        in   ALU write request, held until granted
//   addr_a       in   ALU destination register
//   data_a       in   ALU write data
//   req_b        in   load write request, held until granted
//   addr_b       in   load destination register
//   data_b       in   load write data
//   clear_start  in   one-cycle pulse that starts the clear sequence
//   grant_a      out  combinational; A's request is accepted this cycle
//   grant_b      out  combinational; B's request is accepted this cycle
//   regWrite     out  registered write enable to the register file
//   writeReg     out  registered write address
//   writeData    out  registered write data
//   busy         out  high while the clear sequence is writing
//   clear_done   out  one-cycle pulse after the last clear write
//   state_dbg    out  current FSM state (0 = IDLE, 1 = CLEAR)
//
// Handshake:
//   A requester raises req_x with its addr/data and holds all three stable
//   until grant_x is seen high in the same cycle. The request is consumed at
//   that cycle's posedge. The requester may then drop req_x or present a new
//   request.
//
// Configuration macro:
//   ZERO_REG_PROTECT_EN - when defined, a granted request to address 0 is
//   accepted and released, but it produces no write. The clear engine still
//   writes address 0.
// ---------------------------------------------------------------------------
module regfile_write_scheduler #(
    parameter int NUM_REGS = 8,
    parameter int AW       = 5,
    parameter int DW       = 32
) (
    input  logic          clock_in,
    input  logic          rst,
    input  logic          req_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] data_a,
    input  logic          req_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] data_b,
    input  logic          clear_start,
    output logic          grant_a,
    output logic          grant_b,
    output logic          regWrite,
    output logic [AW-1:0] writeReg,
    output logic [DW-1:0] writeData,
    output logic          busy,
    output logic          clear_done,
    output logic          state_dbg
);

    localparam int CW = $clog2(NUM_REGS + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          prio_q, prio_d;       // 0 = A wins a tie, 1 = B wins a tie
    logic [CW-1:0] cnt_q, cnt_d;
    logic          reg_write_q, reg_write_d;
    logic [AW-1:0] write_reg_q, write_reg_d;
    logic [DW-1:0] write_data_q, write_data_d;
    logic          busy_q, busy_d;
    logic          clear_done_q, clear_done_d;

    logic          arb_ok;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_data;
    logic          win_blocked;

    // Arbitration is open only in IDLE, outside reset, and when no clear is
    // being started. clear_start takes precedence over both requesters.
    assign arb_ok  = !rst && (state_q == IDLE) && !clear_start;
    assign grant_a = arb_ok && req_a && (!req_b || !prio_q);
    assign grant_b = arb_ok && req_b && (!req_a ||  prio_q);

    assign win_addr = grant_a ? addr_a : addr_b;
    assign win_data = grant_a ? data_a : data_b;

`ifdef ZERO_REG_PROTECT_EN
    assign win_blocked = (win_addr == '0);
`else
    assign win_blocked = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        cnt_d        = cnt_q;
        reg_write_d  = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        busy_d       = 1'b0;
        clear_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    // The first clear write (address 0) goes out on this edge,
                    // so busy and the clear writes line up cycle for cycle.
                    state_d      = CLEAR;
                    reg_write_d  = 1'b1;
                    write_reg_d  = '0;
                    write_data_d = '0;
                    cnt_d        = CW'(1);
                    busy_d       = 1'b1;
                end else begin
                    // Only a tie moves the priority pointer.
                    if (req_a && req_b) begin
                        prio_d = !prio_q;
                    end
                    if ((grant_a || grant_b) && !win_blocked) begin
                        reg_write_d  = 1'b1;
                        write_reg_d  = win_addr;
                        write_data_d = win_data;
                    end
                end
            end
            CLEAR: begin
                if (cnt_q == CW'(NUM_REGS)) begin
                    // All writes issued: this edge drops busy and pulses done.
                    state_d      = IDLE;
                    cnt_d        = '0;
                    clear_done_d = 1'b1;
                end else begin
                    reg_write_d  = 1'b1;
                    write_reg_d  = AW'(cnt_q);
                    write_data_d = '0;
                    cnt_d        = cnt_q + CW'(1);
                    busy_d       = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_in or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            prio_q       <= 1'b0;
            cnt_q        <= '0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            cnt_q        <= cnt_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            busy_q       <= busy_d;
            clear_done_q <= clear_done_d;
        end
    end

    assign regWrite   = reg_write_q;
    assign writeReg   = write_reg_q;
    assign writeData  = write_data_q;
    assign busy       = busy_q;
    assign clear_done = clear_done_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
module tb_regfile_write_scheduler;

    localparam int NUM_REGS = 8;
    localparam int AW       = 5;
    localparam int DW       = 32;

    logic          clock_in = 1'b0;
    logic          rst      = 1'b1;
    logic          req_a    = 1'b0;
    logic [AW-1:0] addr_a   = '0;
    logic [DW-1:0] data_a   = '0;
    logic          req_b    = 1'b0;
    logic [AW-1:0] addr_b   = '0;
    logic [DW-1:0] data_b   = '0;
    logic          clear_start = 1'b0;
    logic          grant_a, grant_b, regWrite, busy, clear_done, state_dbg;
    logic [AW-1:0] writeReg;
    logic [DW-1:0] writeData;

    int n_vec = 0;
    int n_bad = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] mon_exp;

    regfile_write_scheduler #(.NUM_REGS(NUM_REGS), .AW(AW), .DW(DW)) dut (
        .clock_in(clock_in), .rst(rst),
        .req_a(req_a), .addr_a(addr_a), .data_a(data_a),
        .req_b(req_b), .addr_b(addr_b), .data_b(data_b),
        .clear_start(clear_start),
        .grant_a(grant_a), .grant_b(grant_b),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .busy(busy), .clear_done(clear_done), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clock_in = ~clock_in;

    // driver helpers
    task automatic cyc();
        @(posedge clock_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({a, d});
    endtask

    // scoreboard monitor: every write presented to the register file is
    // popped against the expected queue
    always @(negedge clock_in) begin
        if (!rst && regWrite) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL wr_unexpected: got reg %0d data %h, required no write",
                         writeReg, writeData);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({writeReg, writeData} !== mon_exp) begin
                    n_bad++;
                    $display("FAIL wr_data: got reg %0d data %h, required reg %0d data %h",
                             writeReg, writeData, mon_exp[AW+DW-1:DW], mon_exp[DW-1:0]);
                end
            end
        end
    end

    initial begin
        // reset state, with a request pending to prove grants stay low
        req_a = 1'b1;
        addr_a = 5'd9;
        #2;
        chk("rst_grant_a",   64'(grant_a),   64'd0);
        chk("rst_regwrite",  64'(regWrite),  64'd0);
        chk("rst_writereg",  64'(writeReg),  64'd0);
        chk("rst_writedata", 64'(writeData), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_done",      64'(clear_done), 64'd0);
        req_a = 1'b0;
        @(posedge clock_in);
        cyc();
        rst = 1'b0;

        // single request from A
        req_a = 1'b1; addr_a = 5'd3; data_a = 32'hDEADBEEF;
        @(negedge clock_in);
        chk("single_grant_a", 64'(grant_a), 64'd1);
        chk("single_grant_b", 64'(grant_b), 64'd0);
        push_wr(5'd3, 32'hDEADBEEF);
        cyc();
        req_a = 1'b0;
        cyc();
        @(negedge clock_in);
        chk("idle_regwrite", 64'(regWrite), 64'd0);
        chk("idle_hold_reg", 64'(writeReg), 64'd3);
        chk("idle_hold_data", 64'(writeData), 64'hDEADBEEF);
        cyc();

        // both held four cycles: A, B, A, B
        for (int i = 0; i < 4; i++) begin
            req_a = 1'b1; addr_a = 5'd1; data_a = 32'hA0 + 32'(i);
            req_b = 1'b1; addr_b = 5'd2; data_b = 32'hB0 + 32'(i);
            @(negedge clock_in);
            if ((i % 2) == 0) begin
                chk("rr_grant_a", 64'(grant_a), 64'd1);
                chk("rr_grant_b", 64'(grant_b), 64'd0);
                push_wr(5'd1, 32'hA0 + 32'(i));
            end else begin
                chk("rr_grant_a", 64'(grant_a), 64'd0);
                chk("rr_grant_b", 64'(grant_b), 64'd1);
                push_wr(5'd2, 32'hB0 + 32'(i));
            end
            cyc();
        end

        // same address from both: winner first, loser next cycle
        addr_a = 5'd5; data_a = 32'h111;
        addr_b = 5'd5; data_b = 32'h222;
        @(negedge clock_in);
        chk("same_grant_a", 64'(grant_a), 64'd1);
        push_wr(5'd5, 32'h111);
        cyc();
        req_a = 1'b0;
        @(negedge clock_in);
        chk("same_grant_b", 64'(grant_b), 64'd1);
        push_wr(5'd5, 32'h222);
        cyc();
        req_b = 1'b0;

        // full clear with A stalled
        req_a = 1'b1; addr_a = 5'd4; data_a = 32'h44;
        clear_start = 1'b1;
        @(negedge clock_in);
        chk("clr_start_grant_a", 64'(grant_a), 64'd0);
        chk("clr_start_busy",    64'(busy),    64'd0);
        for (int i = 0; i < NUM_REGS; i++) push_wr(AW'(i), '0);
        cyc();
        clear_start = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            @(negedge clock_in);
            chk("clr_busy",    64'(busy),       64'd1);
            chk("clr_grant_a", 64'(grant_a),    64'd0);
            chk("clr_done_lo", 64'(clear_done), 64'd0);
            cyc();
        end
        @(negedge clock_in);
        chk("clr_end_busy",    64'(busy),       64'd0);
        chk("clr_end_done",    64'(clear_done), 64'd1);
        chk("clr_end_grant_a", 64'(grant_a),    64'd1);
        push_wr(5'd4, 32'h44);
        cyc();
        req_a = 1'b0;
        @(negedge clock_in);
        chk("clr_done_pulse", 64'(clear_done), 64'd0);
        cyc();

        // reset after three clear writes
        clear_start = 1'b1;
        push_wr(5'd0, '0);
        push_wr(5'd1, '0);
        push_wr(5'd2, '0);
        cyc();
        clear_start = 1'b0;
        cyc();
        cyc();
        @(negedge clock_in);
        #1;
        req_a = 1'b1;
        rst = 1'b1;
        #1;
        chk("abort_grant_a",   64'(grant_a),   64'd0);
        chk("abort_regwrite",  64'(regWrite),  64'd0);
        chk("abort_writereg",  64'(writeReg),  64'd0);
        chk("abort_writedata", 64'(writeData), 64'd0);
        chk("abort_busy",      64'(busy),      64'd0);
        chk("abort_state",     64'(state_dbg), 64'd0);
        req_a = 1'b0;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock_in);
            chk("abort_no_done",  64'(clear_done), 64'd0);
            chk("abort_idle_wr",  64'(regWrite),   64'd0);
            chk("abort_idle_busy", 64'(busy),      64'd0);
            cyc();
        end

        // priority back to A after reset; first IDLE cycle arbitrates
        req_a = 1'b1; addr_a = 5'd6; data_a = 32'h66;
        req_b = 1'b1; addr_b = 5'd7; data_b = 32'h77;
        @(negedge clock_in);
        chk("prio_rst_grant_a", 64'(grant_a), 64'd1);
        chk("prio_rst_grant_b", 64'(grant_b), 64'd0);
        push_wr(5'd6, 32'h66);
        cyc();
        req_a = 1'b0;
        @(negedge clock_in);
        chk("prio_rst_grant_b2", 64'(grant_b), 64'd1);
        push_wr(5'd7, 32'h77);
        cyc();
        req_b = 1'b0;

        // address beyond NUM_REGS passes through
        req_b = 1'b1; addr_b = 5'd20; data_b = 32'h2020;
        @(negedge clock_in);
        chk("hi_addr_grant_b", 64'(grant_b), 64'd1);
        push_wr(5'd20, 32'h2020);
        cyc();
        req_b = 1'b0;

        // write to register 0
        req_b = 1'b1; addr_b = 5'd0; data_b = 32'h55;
        @(negedge clock_in);
        chk("zero_grant_b", 64'(grant_b), 64'd1);
`ifndef ZERO_REG_PROTECT_EN
        push_wr(5'd0, 32'h55);
`endif
        cyc();
        req_b = 1'b0;
        @(negedge clock_in);
`ifdef ZERO_REG_PROTECT_EN
        chk("zero_regwrite", 64'(regWrite), 64'd0);
`else
        chk("zero_regwrite", 64'(regWrite), 64'd1);
        chk("zero_writereg", 64'(writeReg), 64'd0);
`endif
        cyc();
        cyc();

        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
